// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared constants and state encoding for the DTW run sequencer
package dtw_pkg;

  localparam int N_PE   = 6;
  localparam int IDX_W  = 5;
  localparam int ADDR_W = 8;
  // Headroom for band*N_PE+k and step-k without wrap before the range checks
  localparam int CALC_W = IDX_W + 3;

  localparam logic [7:0] TIMEOUT_CYC = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    BTS,
    RUN,
    BT,
    DONE
  } state_t;

endpackage

// File: rtl/dtw_wavefront_gen.sv
// rtl/dtw_wavefront_gen.sv - decodes band/step into per-PE enables and packed t/r indices
module dtw_wavefront_gen
  import dtw_pkg::*;
(
  input  logic                    run,
  input  logic [CALC_W-1:0]       band,
  input  logic [CALC_W-1:0]       step,
  input  logic [IDX_W-1:0]        tlen,
  input  logic [IDX_W-1:0]        rlen,
  output logic [N_PE-1:0]         pe_en,
  output logic [N_PE*IDX_W-1:0]   tindex,
  output logic [N_PE*IDX_W-1:0]   rindex
);

  logic [CALC_W-1:0] t_row;
  logic [CALC_W-1:0] c_col;
  logic              hit;

  always_comb begin
    pe_en  = '0;
    tindex = '0;
    rindex = '0;
    t_row  = '0;
    c_col  = '0;
    hit    = 1'b0;
    for (int k = 0; k < N_PE; k++) begin
      t_row = CALC_W'(band * CALC_W'(N_PE)) + CALC_W'(k);
      c_col = step - CALC_W'(k);
      // step >= k guards the skew: PE k stays idle until the wavefront reaches it
      hit   = run && (step >= CALC_W'(k)) && (c_col <= CALC_W'(rlen))
                  && (t_row <= CALC_W'(tlen));
      pe_en[N_PE-1-k] = hit;
      tindex[(N_PE-1-k)*IDX_W +: IDX_W] = hit ? t_row[IDX_W-1:0] : '0;
      rindex[(N_PE-1-k)*IDX_W +: IDX_W] = hit ? c_col[IDX_W-1:0] : '0;
    end
  end

endmodule

// File: rtl/dtw_seq_ctrl.sv
// rtl/dtw_seq_ctrl.sv - DTW array/backtrace run sequencer; BT watchdog under DTW_SEQ_CTRL_TIMEOUT_EN
module dtw_seq_ctrl
  import dtw_pkg::*;
(
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_start,
  input  logic [IDX_W-1:0]      i_tlen,
  input  logic [IDX_W-1:0]      i_rlen,
  input  logic                  i_bt_valid,
  input  logic                  i_bt_last,
  output logic                  o_busy,
  output logic [N_PE-1:0]       o_pe_en,
  output logic [N_PE*IDX_W-1:0] o_tindex,
  output logic [N_PE*IDX_W-1:0] o_rindex,
  output logic                  o_bt_start,
  output logic                  o_sram_we,
  output logic [ADDR_W-1:0]     o_sram_addr,
  output logic                  o_done,
  output logic                  o_err
);

  state_t            state;
  logic [IDX_W-1:0]  tlen_q;
  logic [IDX_W-1:0]  rlen_q;
  logic [CALC_W-1:0] band;
  logic [CALC_W-1:0] step;
  logic [ADDR_W-1:0] addr;
  logic [CALC_W-1:0] step_last;
  logic              last_band;
  logic              start_acc;
  logic              wd_fire;

  assign start_acc = (state == IDLE) && i_start;
  assign step_last = CALC_W'(rlen_q) + CALC_W'(N_PE - 1);
  // Last band when the next band's first row would already exceed tlen
  assign last_band = (CALC_W'(band * CALC_W'(N_PE)) + CALC_W'(N_PE)) > CALC_W'(tlen_q);

`ifdef DTW_SEQ_CTRL_TIMEOUT_EN
  logic [7:0] wd;
  logic       err_q;

  assign wd_fire = (state == BT) && !i_bt_valid && (wd == TIMEOUT_CYC - 8'd1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_acc) err_q <= 1'b0;
      if (state != BT || i_bt_valid) begin
        wd <= '0;
      end else if (wd_fire) begin
        wd    <= '0;
        err_q <= 1'b1;
      end else begin
        wd <= wd + 8'd1;
      end
    end
  end

  assign o_err = err_q;
`else
  assign wd_fire = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= IDLE;
      tlen_q <= '0;
      rlen_q <= '0;
      band   <= '0;
      step   <= '0;
      addr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_start) begin
            tlen_q <= i_tlen;
            rlen_q <= i_rlen;
            band   <= '0;
            step   <= '0;
            addr   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (step == step_last) begin
            step <= '0;
            if (last_band) state <= BTS;
            else           band  <= band + CALC_W'(1);
          end else begin
            step <= step + CALC_W'(1);
          end
        end
        BTS: state <= BT;
        BT: begin
          if (i_bt_valid) addr <= addr + ADDR_W'(1);
          if ((i_bt_valid && i_bt_last) || wd_fire) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  dtw_wavefront_gen u_wavefront (
    .run    (state == RUN),
    .band   (band),
    .step   (step),
    .tlen   (tlen_q),
    .rlen   (rlen_q),
    .pe_en  (o_pe_en),
    .tindex (o_tindex),
    .rindex (o_rindex)
  );

  assign o_busy      = (state != IDLE);
  assign o_bt_start  = (state == BTS);
  assign o_done      = (state == DONE);
  assign o_sram_addr = addr;
  // The only input-to-output path: the BT word is written the cycle it arrives
  assign o_sram_we   = (state == BT) && i_bt_valid;

endmodule

// File: tb/tb_dtw_seq_ctrl.sv
// tb/tb_dtw_seq_ctrl.sv - directed self-checking bench for dtw_seq_ctrl
module tb_dtw_seq_ctrl;
  import dtw_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_start;
  logic [4:0]  i_tlen;
  logic [4:0]  i_rlen;
  logic        i_bt_valid;
  logic        i_bt_last;
  logic        o_busy;
  logic [5:0]  o_pe_en;
  logic [29:0] o_tindex;
  logic [29:0] o_rindex;
  logic        o_bt_start;
  logic        o_sram_we;
  logic [7:0]  o_sram_addr;
  logic        o_done;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected o_pe_en for steps 0..8 of a band with rlen=3 and all six rows valid
  logic [5:0] en_tab [9] = '{6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b011110,
                             6'b001111, 6'b000111, 6'b000011, 6'b000001};

  always #5 clk = ~clk;

  dtw_seq_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_start     (i_start),
    .i_tlen      (i_tlen),
    .i_rlen      (i_rlen),
    .i_bt_valid  (i_bt_valid),
    .i_bt_last   (i_bt_last),
    .o_busy      (o_busy),
    .o_pe_en     (o_pe_en),
    .o_tindex    (o_tindex),
    .o_rindex    (o_rindex),
    .o_bt_start  (o_bt_start),
    .o_sram_we   (o_sram_we),
    .o_sram_addr (o_sram_addr),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // tlen=5 rlen=3 from start in cycle 0; returns in cycle 11 (first BT cycle)
  task automatic scen_first(input string pfx);
    i_tlen  = 5'd5;
    i_rlen  = 5'd3;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    i_tlen  = 5'd0;
    i_rlen  = 5'd0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      chk({pfx, "_pe_en"}, 32'(o_pe_en), 32'(en_tab[cyc-1]));
      chk({pfx, "_busy"}, 32'(o_busy), 32'd1);
      chk({pfx, "_bt_start_run"}, 32'(o_bt_start), 32'd0);
      if (cyc <= 4) begin
        chk({pfx, "_pe1_r"}, 32'(o_rindex[29:25]), 32'(cyc - 1));
        chk({pfx, "_pe1_t"}, 32'(o_tindex[29:25]), 32'd0);
      end else begin
        chk({pfx, "_pe1_r_off"}, 32'(o_rindex[29:25]), 32'd0);
      end
      if (cyc >= 6) begin
        chk({pfx, "_pe6_t"}, 32'(o_tindex[4:0]), 32'd5);
        chk({pfx, "_pe6_r"}, 32'(o_rindex[4:0]), 32'(cyc - 6));
      end else begin
        chk({pfx, "_pe6_t_off"}, 32'(o_tindex[4:0]), 32'd0);
      end
      if (cyc == 5) begin
        chk({pfx, "_tidx_s4"}, 32'(o_tindex), 32'({5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0}));
        chk({pfx, "_ridx_s4"}, 32'(o_rindex), 32'({5'd0, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0}));
      end
      tick;
    end
    chk({pfx, "_bt_start"}, 32'(o_bt_start), 32'd1);
    chk({pfx, "_pe_en_bts"}, 32'(o_pe_en), 32'd0);
    tick;
    chk({pfx, "_bt_start_end"}, 32'(o_bt_start), 32'd0);
    chk({pfx, "_busy_bt"}, 32'(o_busy), 32'd1);
  endtask

  initial begin
    int n;
    int busy_low;
    int done_cnt;
    int err_cnt;

    nrst       = 1'b0;
    i_start    = 1'b0;
    i_tlen     = 5'd0;
    i_rlen     = 5'd0;
    i_bt_valid = 1'b0;
    i_bt_last  = 1'b0;
    #2;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pe_en", 32'(o_pe_en), 32'd0);
    chk("rst_tidx", 32'(o_tindex), 32'd0);
    chk("rst_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_bt_start", 32'(o_bt_start), 32'd0);
    tick;
    tick;
    nrst = 1'b1;
    tick;

    // Single band, then three BT words with gaps
    scen_first("s1");
    i_bt_valid = 1'b0; #1;
    chk("bt_we_idle", 32'(o_sram_we), 32'd0);
    tick;
    i_bt_valid = 1'b1; #1;
    chk("bt_we0", 32'(o_sram_we), 32'd1);
    chk("bt_addr0", 32'(o_sram_addr), 32'd0);
    tick;
    i_bt_valid = 1'b0; i_bt_last = 1'b1; #1;
    chk("bt_last_novalid_we", 32'(o_sram_we), 32'd0);
    chk("bt_addr1_hold", 32'(o_sram_addr), 32'd1);
    tick;
    i_bt_valid = 1'b1; i_bt_last = 1'b0; #1;
    chk("bt_we1", 32'(o_sram_we), 32'd1);
    chk("bt_addr1", 32'(o_sram_addr), 32'd1);
    chk("bt_no_done_early", 32'(o_done), 32'd0);
    tick;
    i_bt_valid = 1'b0; #1;
    tick;
    i_bt_valid = 1'b1; i_bt_last = 1'b1; #1;
    chk("bt_we2", 32'(o_sram_we), 32'd1);
    chk("bt_addr2", 32'(o_sram_addr), 32'd2);
    tick;
    i_bt_valid = 1'b0; i_bt_last = 1'b0; #1;
    chk("s1_done", 32'(o_done), 32'd1);
    chk("s1_addr_final", 32'(o_sram_addr), 32'd3);
    chk("s1_we_done", 32'(o_sram_we), 32'd0);
    tick;
    chk("s1_done_off", 32'(o_done), 32'd0);
    chk("s1_idle_busy", 32'(o_busy), 32'd0);
    chk("s1_addr_hold", 32'(o_sram_addr), 32'd3);

    // Two bands, start pulse mid-RUN ignored
    i_tlen = 5'd6; i_rlen = 5'd3; i_start = 1'b1;
    tick;
    i_start = 1'b0; i_tlen = 5'd0; i_rlen = 5'd0;
    for (int cyc = 1; cyc <= 18; cyc++) begin
      i_start = (cyc == 5);
      if (cyc <= 9) begin
        chk("s2_b0_pe_en", 32'(o_pe_en), 32'(en_tab[cyc-1]));
      end else begin
        chk("s2_b1_pe_en", 32'(o_pe_en), (cyc - 10 <= 3) ? 32'h20 : 32'h0);
        chk("s2_b1_lo_en", 32'(o_pe_en[4:0]), 32'd0);
        chk("s2_b1_lo_t", 32'(o_tindex[24:0]), 32'd0);
        chk("s2_b1_lo_r", 32'(o_rindex[24:0]), 32'd0);
        if (cyc - 10 <= 3) begin
          chk("s2_b1_pe1_t", 32'(o_tindex[29:25]), 32'd6);
          chk("s2_b1_pe1_r", 32'(o_rindex[29:25]), 32'(cyc - 10));
        end
      end
      chk("s2_bt_start_run", 32'(o_bt_start), 32'd0);
      tick;
    end
    i_start = 1'b0;
    chk("s2_bt_start", 32'(o_bt_start), 32'd1);
    tick;

    // 300 BT words with a start pulse in BT; address wraps 255 -> 0
    busy_low = 0;
    for (int w = 0; w < 300; w++) begin
      i_start    = (w == 0);
      i_bt_valid = 1'b1;
      i_bt_last  = (w == 299);
      #1;
      if (!o_busy) busy_low++;
      if (w == 0 || w == 255 || w == 256 || w == 299)
        chk("wrap_addr", 32'(o_sram_addr), 32'(w % 256));
      if (w == 150) chk("wrap_we", 32'(o_sram_we), 32'd1);
      tick;
    end
    i_start = 1'b0; i_bt_valid = 1'b0; i_bt_last = 1'b0; #1;
    chk("wrap_busy_glitch", 32'(busy_low), 32'd0);
    chk("wrap_done", 32'(o_done), 32'd1);
    chk("wrap_addr_final", 32'(o_sram_addr), 32'd44);
    tick;
    chk("wrap_idle", 32'(o_busy), 32'd0);

    // Asynchronous reset at RUN step 4, then a fresh first scenario
    i_tlen = 5'd5; i_rlen = 5'd3; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    tick; tick; tick; tick;
    chk("rst_pre_pe_en", 32'(o_pe_en), 32'(6'b011110));
    #3;
    nrst = 1'b0;
    #1;
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_pe_en", 32'(o_pe_en), 32'd0);
    chk("arst_tidx", 32'(o_tindex), 32'd0);
    chk("arst_ridx", 32'(o_rindex), 32'd0);
    chk("arst_addr", 32'(o_sram_addr), 32'd0);
    chk("arst_done", 32'(o_done), 32'd0);
    tick;
    chk("arst_hold_busy", 32'(o_busy), 32'd0);
    nrst = 1'b1;
    tick;
    scen_first("s5");
    i_bt_valid = 1'b1; i_bt_last = 1'b1; #1;
    chk("s5_we", 32'(o_sram_we), 32'd1);
    tick;
    i_bt_valid = 1'b0; i_bt_last = 1'b0; #1;
    chk("s5_done", 32'(o_done), 32'd1);
    tick;

    // BT with no valid words: watchdog or indefinite wait
    i_tlen = 5'd0; i_rlen = 5'd0; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int c = 0; c < 6; c++) tick;
    chk("to_bt_start", 32'(o_bt_start), 32'd1);
    tick;
`ifdef DTW_SEQ_CTRL_TIMEOUT_EN
    n = 0;
    while (!o_done && n < 300) begin
      tick;
      n++;
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_done", 32'(o_done), 32'd1);
    chk("to_err", 32'(o_err), 32'd1);
    tick;
    chk("to_err_sticky", 32'(o_err), 32'd1);
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("to_err_clear", 32'(o_err), 32'd0);
    chk("to_restart_busy", 32'(o_busy), 32'd1);
`else
    done_cnt = 0;
    err_cnt  = 0;
    busy_low = 0;
    for (int c = 0; c < 300; c++) begin
      if (o_done) done_cnt++;
      if (o_err) err_cnt++;
      if (!o_busy) busy_low++;
      tick;
    end
    chk("nto_done", 32'(done_cnt), 32'd0);
    chk("nto_err", 32'(err_cnt), 32'd0);
    chk("nto_busy", 32'(busy_low), 32'd0);
    i_bt_valid = 1'b1; #1;
    chk("nto_still_bt", 32'(o_sram_we), 32'd1);
    i_bt_last = 1'b1;
    tick;
    i_bt_valid = 1'b0; i_bt_last = 1'b0; #1;
    chk("nto_done_final", 32'(o_done), 32'd1);
    n = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
